// File: rtl/instruction_fetch_pq_pkg.sv
// Shared definitions for the instruction fetch unit: default fetch parameters,
// request-state encoding and the occupancy-counter width helper.
package instruction_fetch_pq_pkg;

    localparam int unsigned FETCH_PC_STEP  = 4;
    localparam logic [31:0] FETCH_RESET_PC = 32'h0000_0000;

    typedef enum logic {
        REQ_IDLE,
        REQ_PEND
    } req_state_t;

    function automatic int unsigned count_width(input int unsigned depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/instruction_fetch_pq_if.sv
// Instruction-memory syn/ack bus between the fetch unit (master) and memory (slave).
interface instruction_fetch_pq_if #(
    parameter int unsigned A_WIDTH = 32,
    parameter int unsigned I_WIDTH = 32
);
    logic [A_WIDTH-1:0] o_addr_instr;
    logic               o_syn;
    logic               i_ack;
    logic [I_WIDTH-1:0] i_instr;

    modport master (output o_addr_instr, output o_syn, input i_ack, input i_instr);
    modport slave  (input o_addr_instr, input o_syn, output i_ack, output i_instr);
endinterface

// File: rtl/instruction_fetch_pq_fetch_queue.sv
// Synchronous prefetch FIFO holding {instruction, pc} words; flush empties it at the edge.
module fetch_queue
    import instruction_fetch_pq_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 64
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          push,
    input  logic [WIDTH-1:0]              wdata,
    input  logic                          pop,
    input  logic                          flush,
    output logic [WIDTH-1:0]              rdata,
    output logic                          empty,
    output logic [count_width(DEPTH)-1:0] count
);
    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = count_width(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            // Pointers wrap naturally because DEPTH is a power of two.
            if (push) begin
                mem_d[wr_ptr_q] = wdata;
                wr_ptr_d        = wr_ptr_q + PW'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PW'(1);
            end
            count_d = count_q + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign rdata = mem_q[rd_ptr_q];
    assign empty = (count_q == '0);
    assign count = count_q;

endmodule

// File: rtl/instruction_fetch_pq.sv
// Instruction fetch unit: sequential syn/ack fetches into a prefetch queue feeding decode,
// with change_pc redirect that flushes the queue and squashes any in-flight response.
module instruction_fetch_pq
    import instruction_fetch_pq_pkg::*;
#(
    parameter int unsigned          I_WIDTH  = 32,
    parameter int unsigned          A_WIDTH  = 32,
    parameter int unsigned          PC_WIDTH = 32,
    parameter int unsigned          DEPTH    = 4,
    parameter int unsigned          PC_STEP  = FETCH_PC_STEP,
    parameter logic [PC_WIDTH-1:0]  RESET_PC = PC_WIDTH'(FETCH_RESET_PC)
) (
    input  logic                          f_clk,
    input  logic                          f_rst_n,
    instruction_fetch_pq_if.master        mem,
    input  logic                          change_pc,
    input  logic [PC_WIDTH-1:0]           alu_pc_value,
    input  logic                          i_stall,
    output logic [I_WIDTH-1:0]            o_instr,
    output logic [PC_WIDTH-1:0]           pc,
    output logic                          o_ce,
    output logic [count_width(DEPTH)-1:0] o_count
);
    localparam int unsigned CW = count_width(DEPTH);
    localparam int unsigned QW = I_WIDTH + PC_WIDTH;

    req_state_t          state_q, state_d;
    logic [PC_WIDTH-1:0] fetch_pc_q, fetch_pc_d;
    logic [PC_WIDTH-1:0] req_pc_q, req_pc_d;
    logic                drop_q, drop_d;

    logic                accept;
    logic                push;
    logic [CW-1:0]       occ_next;
    logic [QW-1:0]       q_rdata;
    logic                q_empty;
    logic [CW-1:0]       q_count;

    fetch_queue #(
        .DEPTH (DEPTH),
        .WIDTH (QW)
    ) u_queue (
        .clk   (f_clk),
        .rst_n (f_rst_n),
        .push  (push),
        .wdata ({mem.i_instr, fetch_pc_q}),
        .pop   (o_ce),
        .flush (change_pc),
        .rdata (q_rdata),
        .empty (q_empty),
        .count (q_count)
    );

    always_ff @(posedge f_clk or negedge f_rst_n) begin
        if (!f_rst_n) begin
            state_q    <= REQ_IDLE;
            fetch_pc_q <= RESET_PC;
            req_pc_q   <= RESET_PC;
            drop_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            req_pc_q   <= req_pc_d;
            drop_q     <= drop_d;
        end
    end

    always_comb begin
        accept   = (state_q == REQ_PEND) && mem.i_ack;
        push     = accept && !drop_q && !change_pc;
        occ_next = change_pc ? '0 : (q_count + CW'(push) - CW'(o_ce));

        fetch_pc_d = fetch_pc_q;
        if (accept && !drop_q) begin
            fetch_pc_d = fetch_pc_q + PC_WIDTH'(PC_STEP);
        end
        if (change_pc) begin
            fetch_pc_d = alu_pc_value;
        end

        // A redirect while the old request is still unanswered must swallow its response.
        drop_d = drop_q;
        if (change_pc) begin
            drop_d = (state_q == REQ_PEND) && !mem.i_ack;
        end else if (accept) begin
            drop_d = 1'b0;
        end

        // A new request is only issued when a queue slot is guaranteed for its response.
        state_d  = state_q;
        req_pc_d = req_pc_q;
        if (state_q == REQ_IDLE || accept) begin
            if (occ_next < CW'(DEPTH)) begin
                state_d  = REQ_PEND;
                req_pc_d = fetch_pc_d;
            end else begin
                state_d  = REQ_IDLE;
            end
        end
    end

    always_comb begin
        mem.o_syn        = (state_q == REQ_PEND);
        mem.o_addr_instr = A_WIDTH'(req_pc_q);
        o_ce             = !q_empty && !i_stall && !change_pc;
        o_instr          = q_empty ? '0 : q_rdata[QW-1 -: I_WIDTH];
        pc               = q_empty ? '0 : q_rdata[PC_WIDTH-1:0];
        o_count          = q_count;
    end

endmodule

// File: tb/tb_instruction_fetch_pq.sv
// Directed bench for instruction_fetch_pq: per-cycle vector table plus hand-written
// sequences for asynchronous reset mid-burst and PC wrap-around.
module tb_instruction_fetch_pq;

    typedef struct packed {
        logic        ack;
        logic [31:0] instr;
        logic        stall;
        logic        chg;
        logic [31:0] alu;
        logic        e_syn;
        logic [31:0] e_addr;
        logic        e_ce;
        logic [31:0] e_instr;
        logic [31:0] e_pc;
        logic [2:0]  e_cnt;
    } vec_t;

    logic        clk;
    logic        rst_n;
    logic        change_pc;
    logic [31:0] alu_pc_value;
    logic        i_stall;
    logic [31:0] o_instr;
    logic [31:0] pc;
    logic        o_ce;
    logic [2:0]  o_count;

    logic        w_change_pc;
    logic [31:0] w_alu_pc_value;
    logic        w_stall;
    logic [31:0] w_o_instr;
    logic [31:0] w_pc;
    logic        w_o_ce;
    logic [2:0]  w_o_count;

    int errors = 0;
    int checks = 0;
    vec_t vecs[$];

    instruction_fetch_pq_if #(.A_WIDTH(32), .I_WIDTH(32)) mem_if ();
    instruction_fetch_pq_if #(.A_WIDTH(32), .I_WIDTH(32)) w_if ();

    instruction_fetch_pq #(
        .I_WIDTH(32), .A_WIDTH(32), .PC_WIDTH(32), .DEPTH(4), .PC_STEP(4), .RESET_PC(32'h0)
    ) dut (
        .f_clk(clk), .f_rst_n(rst_n), .mem(mem_if),
        .change_pc(change_pc), .alu_pc_value(alu_pc_value), .i_stall(i_stall),
        .o_instr(o_instr), .pc(pc), .o_ce(o_ce), .o_count(o_count)
    );

    instruction_fetch_pq #(
        .I_WIDTH(32), .A_WIDTH(32), .PC_WIDTH(32), .DEPTH(4), .PC_STEP(4), .RESET_PC(32'hFFFF_FFFC)
    ) dut_w (
        .f_clk(clk), .f_rst_n(rst_n), .mem(w_if),
        .change_pc(w_change_pc), .alu_pc_value(w_alu_pc_value), .i_stall(w_stall),
        .o_instr(w_o_instr), .pc(w_pc), .o_ce(w_o_ce), .o_count(w_o_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic ack, input logic [31:0] instr, input logic stall,
                                input logic chg, input logic [31:0] alu, input logic e_syn,
                                input logic [31:0] e_addr, input logic e_ce,
                                input logic [31:0] e_instr, input logic [31:0] e_pc,
                                input logic [2:0] e_cnt);
        vec_t v;
        v.ack = ack;     v.instr = instr;     v.stall = stall; v.chg = chg;   v.alu = alu;
        v.e_syn = e_syn; v.e_addr = e_addr;   v.e_ce = e_ce;
        v.e_instr = e_instr; v.e_pc = e_pc;   v.e_cnt = e_cnt;
        return v;
    endfunction

    initial begin
        //                 ack instr         stl chg alu        syn addr        ce instr         pc          cnt
        // basic ack-every-cycle fetch, 1-cycle ack->o_ce latency
        vecs.push_back(mk(0, 32'h0,         0, 0, 32'h0,     0, 32'h0,       0, 32'h0,         32'h0,      3'd0));
        vecs.push_back(mk(1, 32'hA0A0A0A0,  0, 0, 32'h0,     1, 32'h0,       0, 32'h0,         32'h0,      3'd0));
        vecs.push_back(mk(1, 32'hB1B1B1B1,  0, 0, 32'h0,     1, 32'h4,       1, 32'hA0A0A0A0,  32'h0,      3'd1));
        vecs.push_back(mk(1, 32'hC2C2C2C2,  0, 0, 32'h0,     1, 32'h8,       1, 32'hB1B1B1B1,  32'h4,      3'd1));
        vecs.push_back(mk(0, 32'h0,         0, 0, 32'h0,     1, 32'hC,       1, 32'hC2C2C2C2,  32'h8,      3'd1));
        vecs.push_back(mk(0, 32'h0,         1, 0, 32'h0,     1, 32'hC,       0, 32'h0,         32'h0,      3'd0));
        // stall for 6 cycles with ack high: fill to DEPTH, then o_syn drops
        vecs.push_back(mk(1, 32'h11111111,  1, 0, 32'h0,     1, 32'hC,       0, 32'h0,         32'h0,      3'd0));
        vecs.push_back(mk(1, 32'h22222222,  1, 0, 32'h0,     1, 32'h10,      0, 32'h11111111,  32'hC,      3'd1));
        vecs.push_back(mk(1, 32'h33333333,  1, 0, 32'h0,     1, 32'h14,      0, 32'h11111111,  32'hC,      3'd2));
        vecs.push_back(mk(1, 32'h44444444,  1, 0, 32'h0,     1, 32'h18,      0, 32'h11111111,  32'hC,      3'd3));
        vecs.push_back(mk(1, 32'h55555555,  1, 0, 32'h0,     0, 32'h0,       0, 32'h11111111,  32'hC,      3'd4));
        vecs.push_back(mk(1, 32'h55555555,  1, 0, 32'h0,     0, 32'h0,       0, 32'h11111111,  32'hC,      3'd4));
        vecs.push_back(mk(0, 32'h0,         0, 0, 32'h0,     0, 32'h0,       1, 32'h11111111,  32'hC,      3'd4));
        vecs.push_back(mk(0, 32'h0,         0, 0, 32'h0,     1, 32'h1C,      1, 32'h22222222,  32'h10,     3'd3));
        vecs.push_back(mk(0, 32'h0,         0, 0, 32'h0,     1, 32'h1C,      1, 32'h33333333,  32'h14,     3'd2));
        vecs.push_back(mk(0, 32'h0,         0, 0, 32'h0,     1, 32'h1C,      1, 32'h44444444,  32'h18,     3'd1));
        vecs.push_back(mk(0, 32'h0,         0, 0, 32'h0,     1, 32'h1C,      0, 32'h0,         32'h0,      3'd0));
        // redirect while pending, ack arrives two cycles later and is discarded
        vecs.push_back(mk(1, 32'h66666666,  1, 0, 32'h0,     1, 32'h1C,      0, 32'h0,         32'h0,      3'd0));
        vecs.push_back(mk(0, 32'h0,         1, 1, 32'h100,   1, 32'h20,      0, 32'h66666666,  32'h1C,     3'd1));
        vecs.push_back(mk(0, 32'h0,         0, 0, 32'h0,     1, 32'h20,      0, 32'h0,         32'h0,      3'd0));
        vecs.push_back(mk(1, 32'hDEADBEEF,  0, 0, 32'h0,     1, 32'h20,      0, 32'h0,         32'h0,      3'd0));
        vecs.push_back(mk(1, 32'h77777777,  0, 0, 32'h0,     1, 32'h100,     0, 32'h0,         32'h0,      3'd0));
        vecs.push_back(mk(0, 32'h0,         0, 0, 32'h0,     1, 32'h104,     1, 32'h77777777,  32'h100,    3'd1));
        // redirect in the same cycle as the ack: that word is dropped
        vecs.push_back(mk(1, 32'h99999999,  0, 1, 32'h100,   1, 32'h104,     0, 32'h0,         32'h0,      3'd0));
        vecs.push_back(mk(1, 32'hE4E4E4E4,  0, 0, 32'h0,     1, 32'h100,     0, 32'h0,         32'h0,      3'd0));
        vecs.push_back(mk(1, 32'hF5F5F5F5,  0, 0, 32'h0,     1, 32'h104,     1, 32'hE4E4E4E4,  32'h100,    3'd1));
        vecs.push_back(mk(0, 32'h0,         0, 0, 32'h0,     1, 32'h108,     1, 32'hF5F5F5F5,  32'h104,    3'd1));
        vecs.push_back(mk(0, 32'h0,         0, 0, 32'h0,     1, 32'h108,     0, 32'h0,         32'h0,      3'd0));

        rst_n = 1'b0;
        change_pc = 1'b0; alu_pc_value = '0; i_stall = 1'b0;
        mem_if.i_ack = 1'b0; mem_if.i_instr = '0;
        w_change_pc = 1'b0; w_alu_pc_value = '0; w_stall = 1'b0;
        w_if.i_ack = 1'b0; w_if.i_instr = '0;

        @(negedge clk);
        chk("reset o_syn",   {31'd0, mem_if.o_syn}, 32'd0);
        chk("reset o_ce",    {31'd0, o_ce}, 32'd0);
        chk("reset o_instr", o_instr, 32'd0);
        chk("reset pc",      pc, 32'd0);
        chk("reset o_count", {29'd0, o_count}, 32'd0);
        chk("reset w o_syn", {31'd0, w_if.o_syn}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            mem_if.i_ack   = vecs[i].ack;
            mem_if.i_instr = vecs[i].instr;
            i_stall        = vecs[i].stall;
            change_pc      = vecs[i].chg;
            alu_pc_value   = vecs[i].alu;
            #1;
            chk($sformatf("v%0d o_syn", i), {31'd0, mem_if.o_syn}, {31'd0, vecs[i].e_syn});
            if (vecs[i].e_syn)
                chk($sformatf("v%0d o_addr_instr", i), mem_if.o_addr_instr, vecs[i].e_addr);
            chk($sformatf("v%0d o_ce", i), {31'd0, o_ce}, {31'd0, vecs[i].e_ce});
            chk($sformatf("v%0d o_instr", i), o_instr, vecs[i].e_instr);
            chk($sformatf("v%0d pc", i), pc, vecs[i].e_pc);
            chk($sformatf("v%0d o_count", i), {29'd0, o_count}, {29'd0, vecs[i].e_cnt});
            @(negedge clk);
        end

        // Three stalled pushes, then async reset mid-cycle while a request is pending.
        change_pc = 1'b0; i_stall = 1'b1;
        mem_if.i_ack = 1'b1; mem_if.i_instr = 32'hAAAA0001;
        @(negedge clk);
        mem_if.i_instr = 32'hAAAA0002;
        @(negedge clk);
        mem_if.i_instr = 32'hAAAA0003;
        @(negedge clk);
        mem_if.i_ack = 1'b0; i_stall = 1'b0;
        #1;
        chk("burst o_count", {29'd0, o_count}, 32'd3);
        chk("burst o_syn",   {31'd0, mem_if.o_syn}, 32'd1);
        chk("burst o_ce",    {31'd0, o_ce}, 32'd1);
        chk("burst pc",      pc, 32'h108);
        chk("burst o_instr", o_instr, 32'hAAAA0001);
        #2 rst_n = 1'b0;
        #1;
        chk("async rst o_syn",   {31'd0, mem_if.o_syn}, 32'd0);
        chk("async rst o_ce",    {31'd0, o_ce}, 32'd0);
        chk("async rst o_instr", o_instr, 32'd0);
        chk("async rst pc",      pc, 32'd0);
        chk("async rst o_count", {29'd0, o_count}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("post rst o_syn", {31'd0, mem_if.o_syn}, 32'd0);
        @(negedge clk);
        #1;
        chk("restart o_syn",  {31'd0, mem_if.o_syn}, 32'd1);
        chk("restart o_addr", mem_if.o_addr_instr, 32'h0);
        mem_if.i_ack = 1'b1; mem_if.i_instr = 32'h0BADF00D;
        @(negedge clk);
        mem_if.i_ack = 1'b0;
        #1;
        chk("restart o_ce",    {31'd0, o_ce}, 32'd1);
        chk("restart pc",      pc, 32'h0);
        chk("restart o_instr", o_instr, 32'h0BADF00D);

        // PC wrap on the second instance, reset to 0xFFFFFFFC.
        w_if.i_ack = 1'b1; w_if.i_instr = 32'h12345678;
        #1;
        chk("wrap first addr", w_if.o_addr_instr, 32'hFFFF_FFFC);
        chk("wrap first syn",  {31'd0, w_if.o_syn}, 32'd1);
        @(negedge clk);
        w_if.i_instr = 32'h9ABCDEF0;
        #1;
        chk("wrap second addr", w_if.o_addr_instr, 32'h0);
        chk("wrap pc0",         w_pc, 32'hFFFF_FFFC);
        chk("wrap instr0",      w_o_instr, 32'h12345678);
        chk("wrap ce0",         {31'd0, w_o_ce}, 32'd1);
        @(negedge clk);
        w_if.i_ack = 1'b0;
        #1;
        chk("wrap pc1",    w_pc, 32'h0);
        chk("wrap instr1", w_o_instr, 32'h9ABCDEF0);
        chk("wrap ce1",    {31'd0, w_o_ce}, 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
